// File: rtl/rc5_decrypt_core_if.sv
// ---------------------------------------------------------------------------
// rc5_decrypt_core_if
// Bundles the request/response handshake of the RC5 decryption core together
// with the read port into the expanded key table S[0..t-1].
//
// Signals
//   start      request, sampled by the core only while idle
//   A_in/B_in  ciphertext word pair
//   S_address  registered read address into the S table (driven by the core)
//   S_sub_i    S[S_address], combinational read data (driven by the table)
//   A_out/B_out plaintext word pair, held until the next completion
//   busy       high while a decryption is in progress
//   done       one-cycle pulse when A_out/B_out are valid
//
// Modports
//   master  requester side that also owns the S table
//   slave   the decryption core
// ---------------------------------------------------------------------------
interface rc5_decrypt_core_if #(
    parameter int w = 32,
    parameter int r = 12
);
    localparam int t        = 2 * (r + 1);
    localparam int t_length = $clog2(t);

    logic                start;
    logic [w-1:0]        A_in;
    logic [w-1:0]        B_in;
    logic [t_length-1:0] S_address;
    logic [w-1:0]        S_sub_i;
    logic [w-1:0]        A_out;
    logic [w-1:0]        B_out;
    logic                busy;
    logic                done;

    modport master (
        output start, A_in, B_in, S_sub_i,
        input  S_address, A_out, B_out, busy, done
    );

    modport slave (
        input  start, A_in, B_in, S_sub_i,
        output S_address, A_out, B_out, busy, done
    );
endinterface

// File: rtl/rc5_decrypt_core.sv
// ---------------------------------------------------------------------------
// rc5_decrypt_core
// Iterative RC5-w/r decryption engine. One half-round is applied per clock,
// walking the expanded key table from S[t-1] down to S[0]. The plaintext
// pair appears on A_out/B_out together with a one-cycle done pulse, t clock
// edges after the edge that accepted start.
//
// Ports
//   i_clk1  single clock, rising edge
//   i_rst   asynchronous reset, active low
//   bus     rc5_decrypt_core_if.slave : start, A_in, B_in, S_address,
//           S_sub_i, A_out, B_out, busy, done
// ---------------------------------------------------------------------------
module rc5_decrypt_core #(
    parameter int w = 32,
    parameter int r = 12
) (
    input  logic                i_clk1,
    input  logic                i_rst,
    rc5_decrypt_core_if.slave   bus
);
    localparam int t          = 2 * (r + 1);
    localparam int t_length   = $clog2(t);
    localparam int rot_length = $clog2(w);

    localparam logic [t_length-1:0] K_LAST = t_length'(t - 1);
    localparam logic [t_length-1:0] K_ONE  = t_length'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              r_state;
    logic [t_length-1:0] r_k;
    logic [w-1:0]        r_a;
    logic [w-1:0]        r_b;
    logic [w-1:0]        r_aOut;
    logic [w-1:0]        r_bOut;
    logic                r_busy;
    logic                r_done;

    logic [w-1:0]        w_aSub;
    logic [w-1:0]        w_bSub;
    logic [w-1:0]        w_aRound;
    logic [w-1:0]        w_bRound;

    // Rotating the doubled word keeps every amount 0..w-1 exact and never
    // produces a shift by the full word width.
    function automatic logic [w-1:0] rotr(input logic [w-1:0]          x,
                                          input logic [rot_length-1:0] s);
        logic [2*w-1:0] d;
        d = {x, x} >> s;
        return d[w-1:0];
    endfunction

    // The step counter doubles as the table address, so S_sub_i is S[k]
    // for the whole cycle in which step k is applied.
    assign bus.S_address = r_k;
    assign bus.A_out     = r_aOut;
    assign bus.B_out     = r_bOut;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    // Half-round datapath: the odd step updates B using A as rotate amount,
    // the following even step updates A using the freshly updated B.
    assign w_aSub   = r_a - bus.S_sub_i;
    assign w_bSub   = r_b - bus.S_sub_i;
    assign w_aRound = rotr(w_aSub, r_b[rot_length-1:0]) ^ r_b;
    assign w_bRound = rotr(w_bSub, r_a[rot_length-1:0]) ^ r_a;

    // Control FSM with registered outputs. Step 0 completes the final
    // whitening subtraction directly into the output registers.
    always_ff @(posedge i_clk1 or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_aOut  <= '0;
            r_bOut  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.A_in;
                        r_b     <= bus.B_in;
                        r_k     <= K_LAST;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (r_k == '0) begin
                        r_a     <= w_aSub;
                        r_aOut  <= w_aSub;
                        r_bOut  <= r_b;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        if (r_k == K_ONE) begin
                            r_b <= w_bSub;
                        end else if (r_k[0]) begin
                            r_b <= w_bRound;
                        end else begin
                            r_a <= w_aRound;
                        end
                        r_k <= r_k - K_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_rc5_decrypt_core
// Scoreboard bench for rc5_decrypt_core (RC5-32/12). Each accepted request
// pushes its expected plaintext and completion cycle into a queue; a monitor
// pops and compares on every done pulse. The bench owns a reference key
// expansion and encryptor used to build ciphertexts and S tables.
// ---------------------------------------------------------------------------
module tb_rc5_decrypt_core;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } expT;

    logic        clk;
    logic        rst_n;
    int          cycle;
    int          total;
    int          bad;
    int          doneCount;
    logic        prevDone;
    expT         sbQ[$];
    expT         monE;
    logic [31:0] sTab[0:31];
    logic [31:0] lastPtA;
    logic [31:0] lastPtB;

    rc5_decrypt_core_if bus ();

    rc5_decrypt_core dut (
        .i_clk1 (clk),
        .i_rst  (rst_n),
        .bus    (bus)
    );

    // Behavioural S table read port, combinational on the core's address.
    assign bus.S_sub_i = sTab[bus.S_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] rotrRef(input logic [31:0] x, input logic [4:0] s);
        logic [4:0] ns;
        ns = 5'd0 - s;
        return rotl(x, ns);
    endfunction

    task automatic expandKey(input logic [31:0] k0, k1, k2, k3);
        logic [31:0] l[4];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ab;
        int          i;
        int          j;
        l[0] = k0; l[1] = k1; l[2] = k2; l[3] = k3;
        for (int n = 0; n < 32; n++) sTab[n] = 32'h0;
        sTab[0] = 32'hB7E15163;
        for (int n = 1; n < 26; n++) sTab[n] = sTab[n-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int n = 0; n < 78; n++) begin
            a       = rotl(sTab[i] + a + b, 5'd3);
            sTab[i] = a;
            ab      = a + b;
            b       = rotl(l[j] + ab, ab[4:0]);
            l[j]    = b;
            i       = (i + 1) % 26;
            j       = (j + 1) % 4;
        end
    endtask

    task automatic refEncrypt(input logic [31:0] pa, pb, output logic [31:0] ca, cb);
        logic [31:0] a;
        logic [31:0] b;
        a = pa + sTab[0];
        b = pb + sTab[1];
        for (int i = 1; i <= 12; i++) begin
            a = rotl(a ^ b, b[4:0]) + sTab[2*i];
            b = rotl(b ^ a, a[4:0]) + sTab[2*i+1];
        end
        ca = a;
        cb = b;
    endtask

    task automatic refDecrypt(input logic [31:0] ca, cb, output logic [31:0] pa, pb);
        logic [31:0] a;
        logic [31:0] b;
        a = ca;
        b = cb;
        for (int i = 12; i >= 1; i--) begin
            b = rotrRef(b - sTab[2*i+1], a[4:0]) ^ a;
            a = rotrRef(a - sTab[2*i], b[4:0]) ^ b;
        end
        pb = b - sTab[1];
        pa = a - sTab[0];
    endtask

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            checkOutput("donePulseWidth", {31'b0, prevDone}, 32'h0);
            doneCount++;
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedDone: got done with no request outstanding (cycle %0d)", cycle);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("A_out", bus.A_out, monE.a);
                checkOutput("B_out", bus.B_out, monE.b);
                checkOutput("doneCycle", cycle, monE.cyc);
            end
        end
        prevDone = bus.done;
    end

    // ---------------- stimulus ----------------
    task automatic waitDrain();
        int n;
        n = 0;
        while ((sbQ.size() != 0 || bus.busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("[TB] FAIL drainTimeout: got %0d outstanding expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    // Issues one request from a negedge; the expectation is pushed with the
    // cycle of the accepting edge plus 26.
    task automatic applyStimulus(input logic [31:0] ctA, ctB, ptA, ptB);
        expT e;
        waitDrain();
        bus.start = 1'b1;
        bus.A_in  = ctA;
        bus.B_in  = ctB;
        @(negedge clk);
        bus.start = 1'b0;
        e.a   = ptA;
        e.b   = ptB;
        e.cyc = cycle + 26;
        sbQ.push_back(e);
        lastPtA = ptA;
        lastPtB = ptB;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] pa, pb, ca, cb, pa2, pb2, ca2, cb2;
        int          savedDone;
        expT         e;

        total = 0; bad = 0; doneCount = 0; prevDone = 1'b0; cycle = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.A_in = '0; bus.B_in = '0;
        for (int n = 0; n < 32; n++) sTab[n] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rstS_address", 32'(bus.S_address), 32'h0);
        checkOutput("rstA_out", bus.A_out, 32'h0);
        checkOutput("rstB_out", bus.B_out, 32'h0);
        checkOutput("rstBusy", {31'b0, bus.busy}, 32'h0);
        checkOutput("rstDone", {31'b0, bus.done}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known answer: zero key, RC5-32/12/16 vector, plus address walk
        expandKey(32'h0, 32'h0, 32'h0, 32'h0);
        applyStimulus(32'hEEDBA521, 32'h6D8F4B15, 32'h00000000, 32'h00000000);
        checkOutput("busyInRun", {31'b0, bus.busy}, 32'h1);
        for (int j = 0; j < 26; j++) begin
            checkOutput("S_addressSeq", 32'(bus.S_address), 32'(25 - j));
            @(negedge clk);
        end
        waitDrain();

        // Round trip with random keys and plaintexts
        for (int n = 0; n < 50; n++) begin
            waitDrain();
            expandKey($urandom, $urandom, $urandom, $urandom);
            pa = $urandom;
            pb = $urandom;
            refEncrypt(pa, pb, ca, cb);
            applyStimulus(ca, cb, pa, pb);
        end
        waitDrain();

        // Rotate boundaries: amounts 0 and 31
        for (int n = 0; n < 32; n++) sTab[n] = 32'h0;
        refDecrypt(32'h00000000, 32'h0000001F, pa, pb);
        applyStimulus(32'h00000000, 32'h0000001F, pa, pb);
        waitDrain();
        expandKey(32'h0, 32'h0, 32'h0, 32'h0);
        refDecrypt(32'hA5A5A5BF, 32'h1234567F, pa, pb);
        applyStimulus(32'hA5A5A5BF, 32'h1234567F, pa, pb);
        waitDrain();

        // Handshake: start held high, inputs toggling during RUN
        pa = $urandom; pb = $urandom;
        refEncrypt(pa, pb, ca, cb);
        pa2 = $urandom; pb2 = $urandom;
        refEncrypt(pa2, pb2, ca2, cb2);
        bus.start = 1'b1;
        bus.A_in  = ca;
        bus.B_in  = cb;
        @(negedge clk);
        e.a = pa; e.b = pb; e.cyc = cycle + 26;
        sbQ.push_back(e);
        repeat (25) begin
            @(negedge clk);
            bus.A_in = $urandom;
            bus.B_in = $urandom;
        end
        @(negedge clk);
        bus.A_in = ca2;
        bus.B_in = cb2;
        @(negedge clk);
        e.a = pa2; e.b = pb2; e.cyc = cycle + 26;
        sbQ.push_back(e);
        lastPtA = pa2;
        lastPtB = pb2;
        bus.start = 1'b0;
        checkOutput("busyBackToBack", {31'b0, bus.busy}, 32'h1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.A_in  = $urandom;
        bus.B_in  = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        waitDrain();
        repeat (30) @(negedge clk);

        // Output hold while idle with changing inputs and table
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.A_in = $urandom;
            bus.B_in = $urandom;
            for (int n = 0; n < 32; n++) sTab[n] = $urandom;
            if ((i % 25) == 24) begin
                checkOutput("holdA_out", bus.A_out, lastPtA);
                checkOutput("holdB_out", bus.B_out, lastPtB);
                checkOutput("holdBusy", {31'b0, bus.busy}, 32'h0);
                checkOutput("holdDone", {31'b0, bus.done}, 32'h0);
            end
        end

        // Reset mid-operation at k=10
        expandKey($urandom, $urandom, $urandom, $urandom);
        pa = $urandom; pb = $urandom;
        refEncrypt(pa, pb, ca, cb);
        applyStimulus(ca, cb, pa, pb);
        repeat (15) @(negedge clk);
        checkOutput("midRunAddress", 32'(bus.S_address), 32'd10);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstS_address", 32'(bus.S_address), 32'h0);
        checkOutput("asyncRstA_out", bus.A_out, 32'h0);
        checkOutput("asyncRstB_out", bus.B_out, 32'h0);
        checkOutput("asyncRstBusy", {31'b0, bus.busy}, 32'h0);
        checkOutput("asyncRstDone", {31'b0, bus.done}, 32'h0);
        sbQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        savedDone = doneCount;
        repeat (40) @(negedge clk);
        checkOutput("noDoneAfterReset", doneCount, savedDone);
        checkOutput("idleAfterReset", {31'b0, bus.busy}, 32'h0);

        // Fresh operation after reset
        pa = $urandom; pb = $urandom;
        refEncrypt(pa, pb, ca, cb);
        applyStimulus(ca, cb, pa, pb);
        waitDrain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
